fp_normalize_pack: RTL

FP_NORMALIZE_PACK -- requirements
Module: fp_normalize_pack

---
 rtl/fp_normalize_pack.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fp_normalize_pack.sv
// ---------------------------------------------------------------------------
// fp_normalize_pack
//
// Normalizes an unnormalized single-precision mantissa coming from the ALU
// and packs it into an IEEE-754 word {sign, exponent[7:0], fraction[22:0]}.
// Normalization is a one-bit-per-cycle left shift, so a result with k
// leading zeros needs k SHIFT cycles before it can be packed.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE while reset is low; out_valid is
// held, with Result and flags stable, until out_ready is seen high.
//
// Build option:
//   FP_NORMALIZE_ROUND_EN  when defined, the bit dropped by the carry
//                          right-shift is rounded to nearest-even; when
//                          undefined it is truncated.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_valid/in_ready input handshake
//   alignedResult     24-bit unnormalized mantissa magnitude
//   alignedSign       result sign
//   carryOut          mantissa add carry-out
//   exponentOut       common biased exponent
//   out_valid/out_ready output handshake
//   Result            packed single-precision word
//   overflow, underflow, zero  status for Result (mutually exclusive)
//   fsm_state         current FSM state (0 IDLE, 1 SHIFT, 2 OUT) for debug
// ---------------------------------------------------------------------------
module fp_normalize_pack (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] alignedResult,
    input  logic        alignedSign,
    input  logic        carryOut,
    input  logic [7:0]  exponentOut,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Result,
    output logic        overflow,
    output logic        underflow,
    output logic        zero,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t      state;
    logic [23:0] mant_q;
    logic [7:0]  exp_q;
    logic        sign_q;

    logic        accept;
    logic [23:0] carry_mant;
    logic [8:0]  carry_exp;
    logic        carry_ovf;

    assign in_ready  = (state == IDLE) && !reset;
    assign accept    = in_valid && in_ready;
    assign fsm_state = state;

    // Carry case: the implicit one moves to bit 24, so the mantissa is
    // shifted right by one and the exponent bumped. The exponent is kept
    // 9 bits wide so an exponentOut of 8'hFF saturates to overflow instead
    // of wrapping to zero.
    always_comb begin
        carry_mant = {1'b1, alignedResult[23:1]};
        carry_exp  = {1'b0, exponentOut} + 9'd1;
`ifdef FP_NORMALIZE_ROUND_EN
        // Round to nearest-even on the single dropped bit: a tie rounds up
        // only when the kept LSB is odd.
        if (alignedResult[0] && alignedResult[1]) begin
            if (&carry_mant) begin
                carry_mant = 24'h800000;
                carry_exp  = carry_exp + 9'd1;
            end else begin
                carry_mant = carry_mant + 24'd1;
            end
        end
`endif
    end

    assign carry_ovf = (carry_exp >= 9'd255);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            Result    <= 32'h0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            zero      <= 1'b0;
            mant_q    <= 24'h0;
            exp_q     <= 8'h0;
            sign_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_q    <= alignedSign;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        zero      <= 1'b0;
                        if (alignedResult == 24'h0 && !carryOut) begin
                            Result    <= {alignedSign, 31'h0};
                            zero      <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= OUT;
                        end else if (carryOut) begin
                            if (carry_ovf) begin
                                Result    <= {alignedSign, 8'hFF, 23'h0};
                                overflow  <= 1'b1;
                                out_valid <= 1'b1;
                                state     <= OUT;
                            end else begin
                                mant_q <= carry_mant;
                                exp_q  <= carry_exp[7:0];
                                state  <= SHIFT;
                            end
                        end else begin
                            mant_q <= alignedResult;
                            exp_q  <= exponentOut;
                            state  <= SHIFT;
                        end
                    end
                end

                SHIFT: begin
                    if (mant_q[23]) begin
                        Result    <= {sign_q, exp_q, mant_q[22:0]};
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else if (exp_q > 8'd1) begin
                        mant_q <= {mant_q[22:0], 1'b0};
                        exp_q  <= exp_q - 8'd1;
                    end else begin
                        // Exponent exhausted before the leading one reached
                        // bit 23: flush to a signed zero.
                        Result    <= {sign_q, 31'h0};
                        underflow <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end

                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
